// File: rtl/cnn_pkg.sv
// ============================================================================
// cnn_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the CNN layer pipeline (convolution output stage,
// pooling stage).
//   - DATA_WIDTH / pixel_t : default signed pixel type used across the layers
//   - MAX_WIDTH            : widest operand the shared compare helper accepts
//   - addr_width()         : clog2-based address width, never less than 1
//   - max2()               : signed two-input maximum
// ============================================================================
package cnn_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int MAX_WIDTH  = 32;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    // Depths of 1 or 2 still need a one-bit address so ports never collapse
    // to zero width.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Callers sign-extend narrower pixels to MAX_WIDTH and truncate the
    // result back, so one helper serves every pixel width.
    function automatic logic signed [MAX_WIDTH-1:0] max2(
        input logic signed [MAX_WIDTH-1:0] a,
        input logic signed [MAX_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// ============================================================================
// pool_linebuf
// ----------------------------------------------------------------------------
// Simple dual-port RAM holding one entry per horizontal pixel pair of a row.
// Synchronous write, combinational read, so it maps onto distributed RAM.
// Contents are not reset.
//
// Ports:
//   i_clk    - write clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data (combinational from i_raddr)
// ============================================================================
module pool_linebuf
    import cnn_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/maxpool_stream.sv
// ============================================================================
// maxpool_stream
// ----------------------------------------------------------------------------
// Streaming 2x2 / stride-2 max pooling over a raster-order signed pixel
// stream. Even rows store the max of each horizontal pixel pair in a
// half-width line buffer; odd rows combine their own pair max with the stored
// value and emit one pooled pixel per window, one cycle after the window's
// bottom-right pixel.
//
// Optional feature (compile-time macro):
//   MAXPOOL_RELU_EN - clamp negative pooled values to zero in the output
//                     register stage (latency unchanged).
//
// Ports:
//   i_clk        - rising-edge clock
//   i_reset      - synchronous active-high reset
//   i_data_valid - i_data carries a pixel this cycle (gaps allowed)
//   i_data       - input pixel, two's complement
//   o_data_valid - one-cycle pulse per pooled pixel
//   o_data       - pooled pixel, held until the next output
//   o_frame_done - one-cycle pulse with the last pooled pixel of a frame
// ============================================================================
module maxpool_stream
    import cnn_pkg::*;
#(
    parameter int imageWidth  = 256,
    parameter int imageHeight = 256,
    parameter int dataWidth   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_data_valid,
    input  logic [dataWidth-1:0] i_data,
    output logic                 o_data_valid,
    output logic [dataWidth-1:0] o_data,
    output logic                 o_frame_done
);

    // Reject geometries the windowing cannot handle at elaboration time.
    if ((imageWidth % 2) != 0 || imageWidth < 2) begin : g_bad_width
        $error("maxpool_stream: imageWidth must be even and at least 2");
    end
    if ((imageHeight % 2) != 0 || imageHeight < 2) begin : g_bad_height
        $error("maxpool_stream: imageHeight must be even and at least 2");
    end
    if (dataWidth < 1 || dataWidth > MAX_WIDTH) begin : g_bad_data_width
        $error("maxpool_stream: dataWidth out of supported range");
    end

    localparam int COL_W     = addr_width(imageWidth);
    localparam int ROW_W     = addr_width(imageHeight);
    localparam int LB_DEPTH  = imageWidth / 2;
    localparam int LB_ADDR_W = addr_width(LB_DEPTH);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(imageWidth - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(imageHeight - 1);

    logic [COL_W-1:0]            col_q, col_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic signed [dataWidth-1:0] hold_q, hold_d;
    logic signed [dataWidth-1:0] out_q, out_d;
    logic                        valid_q, valid_d;
    logic                        done_q, done_d;

    logic signed [dataWidth-1:0] in_pix;
    logic signed [dataWidth-1:0] pair_max;
    logic signed [dataWidth-1:0] window_max;
    logic signed [dataWidth-1:0] pooled;
    logic signed [dataWidth-1:0] lb_rdata;
    logic [LB_ADDR_W-1:0]        lb_addr;
    logic                        lb_we;

    assign in_pix = i_data;

    // Pair max serves both roles: line-buffer write data on even rows and
    // the first half of the window compare on odd rows.
    assign pair_max   = dataWidth'(max2(MAX_WIDTH'(hold_q), MAX_WIDTH'(in_pix)));
    assign window_max = dataWidth'(max2(MAX_WIDTH'(pair_max), MAX_WIDTH'(lb_rdata)));

`ifdef MAXPOOL_RELU_EN
    assign pooled = window_max[dataWidth-1] ? '0 : window_max;
`else
    assign pooled = window_max;
`endif

    // Read and write share one address: even rows only write and odd rows
    // only read, so the two never collide.
    assign lb_addr = LB_ADDR_W'(col_q >> 1);

    pool_linebuf #(
        .DEPTH  (LB_DEPTH),
        .WIDTH  (dataWidth),
        .ADDR_W (LB_ADDR_W)
    ) u_linebuf (
        .i_clk   (i_clk),
        .i_we    (lb_we),
        .i_waddr (lb_addr),
        .i_wdata (pair_max),
        .i_raddr (lb_addr),
        .o_rdata (lb_rdata)
    );

    // Everything advances only on a valid pixel, so input gaps freeze the
    // datapath. Reset suppresses the line-buffer write of a coincident pixel.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        lb_we   = 1'b0;

        if (i_data_valid && !i_reset) begin
            if (!col_q[0]) begin
                hold_d = in_pix;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_d   = pooled;
                valid_d = 1'b1;
                done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_data       = out_q;
    assign o_data_valid = valid_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// ============================================================================
// tb_maxpool_stream
// ----------------------------------------------------------------------------
// Self-checking bench for maxpool_stream. A 4x4 instance exercises directed
// frames (ramp, signed window, input gaps, mid-frame reset, back-to-back
// frames); a 256-wide instance streams random frames. Expected outputs come
// from a window-by-window reference over the stored frame pixels.
// Honours MAXPOOL_RELU_EN the same way as the design.
// ============================================================================
module tb_maxpool_stream;

    localparam int DW = 8;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int BW = 256;
    localparam int BH = 32;
    localparam int BFRAMES = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Small instance signals
    logic          sReset, sValid, sOutValid, sDone;
    logic [DW-1:0] sData, sOutData;
    // Large instance signals
    logic          bReset, bValid, bOutValid, bDone;
    logic [DW-1:0] bData, bOutData;

    maxpool_stream #(.imageWidth(SW), .imageHeight(SH), .dataWidth(DW)) dut_small (
        .i_clk        (clk),
        .i_reset      (sReset),
        .i_data_valid (sValid),
        .i_data       (sData),
        .o_data_valid (sOutValid),
        .o_data       (sOutData),
        .o_frame_done (sDone)
    );

    maxpool_stream #(.imageWidth(BW), .imageHeight(BH), .dataWidth(DW)) dut_big (
        .i_clk        (clk),
        .i_reset      (bReset),
        .i_data_valid (bValid),
        .i_data       (bData),
        .o_data_valid (bOutValid),
        .o_data       (bOutData),
        .o_frame_done (bDone)
    );

    // Observed outputs, captured on the falling edge
    logic signed [DW-1:0] sObsData[$];
    logic                 sObsDone[$];
    int                   sObsCyc[$];
    int                   sStrayDone = 0;
    logic signed [DW-1:0] bObsData[$];
    logic                 bObsDone[$];
    int                   bObsCyc[$];
    int                   bStrayDone = 0;

    // Expected outputs from the reference model
    int   sExpData[$];
    logic sExpDone[$];
    int   sExpCyc[$];
    int   bExpData[$];
    logic bExpDone[$];
    int   bExpCyc[$];

    int bPix[BW*BH];
    int bDrv[BW*BH];

    always @(negedge clk) begin
        if (sOutValid === 1'b1) begin
            sObsData.push_back(sOutData);
            sObsDone.push_back(sDone);
            sObsCyc.push_back(cyc);
        end else if (sDone !== 1'b0) begin
            sStrayDone++;
        end
        if (bOutValid === 1'b1) begin
            bObsData.push_back(bOutData);
            bObsDone.push_back(bDone);
            bObsCyc.push_back(cyc);
        end else if (bDone !== 1'b0) begin
            bStrayDone++;
        end
    end

    // Reference: maximum of one 2x2 window, optionally clamped at zero
    function automatic int pool4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one 4x4 frame into the small instance, 'gap' idle cycles after
    // each pixel, and append that frame's expected windows.
    task automatic applyStimulus(input int pix[16], input int gap);
        int drv[16];
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sValid = 1'b1;
            sData  = DW'(pix[i]);
            drv[i] = cyc;
            repeat (gap) begin
                @(negedge clk);
                sValid = 1'b0;
                sData  = DW'($urandom);
            end
        end
        for (int r = 0; r < SH/2; r++) begin
            for (int c = 0; c < SW/2; c++) begin
                sExpData.push_back(pool4(pix[2*r*SW + 2*c], pix[2*r*SW + 2*c + 1],
                                         pix[(2*r+1)*SW + 2*c], pix[(2*r+1)*SW + 2*c + 1]));
                sExpDone.push_back((r == SH/2-1) && (c == SW/2-1));
                sExpCyc.push_back(drv[(2*r+1)*SW + 2*c + 1] + 1);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            sValid = 1'b0;
            bValid = 1'b0;
        end
    endtask

    task automatic checkSmall(input string tag);
        checkOutput({tag, "_count"}, sObsData.size(), sExpData.size());
        for (int i = 0; i < sExpData.size() && i < sObsData.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), sObsData[i], sExpData[i]);
            checkOutput($sformatf("%s_done%0d", tag, i), sObsDone[i], sExpDone[i]);
            checkOutput($sformatf("%s_cyc%0d", tag, i), sObsCyc[i], sExpCyc[i]);
        end
        sObsData.delete(); sObsDone.delete(); sObsCyc.delete();
        sExpData.delete(); sExpDone.delete(); sExpCyc.delete();
    endtask

    initial begin
        int p[16];
        int lit[4];
        int doneCount;

        sReset = 1'b1; sValid = 1'b0; sData = '0;
        bReset = 1'b1; bValid = 1'b0; bData = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_valid", sOutValid, 0);
        checkOutput("rst_data", sOutData, 0);
        checkOutput("rst_done", sDone, 0);
        checkOutput("rst_big_valid", bOutValid, 0);
        sReset = 1'b0;
        bReset = 1'b0;

        $display("[TB] ramp frame, continuous valid");
        for (int i = 0; i < 16; i++) p[i] = i + 1;
        applyStimulus(p, 0);
        idleCycles(3);
        lit = '{6, 8, 14, 16};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ramp_lit%0d", i),
                        (i < sObsData.size()) ? 32'(sObsData[i]) : 32'hDEAD_BEEF, lit[i]);
        end
        checkSmall("ramp");

        $display("[TB] signed window");
        p = '{-3, -7, 5, 2, -1, -128, 4, 9, 10, 11, 12, 13, 14, 15, 16, 17};
        applyStimulus(p, 0);
        idleCycles(3);
`ifdef MAXPOOL_RELU_EN
        checkOutput("signed_lit", (sObsData.size() > 0) ? 32'(sObsData[0]) : 32'hDEAD_BEEF, 0);
`else
        checkOutput("signed_lit", (sObsData.size() > 0) ? 32'(sObsData[0]) : 32'hDEAD_BEEF, -1);
`endif
        checkSmall("signed");

        $display("[TB] ramp frame with 3-cycle gaps");
        for (int i = 0; i < 16; i++) p[i] = i + 1;
        applyStimulus(p, 3);
        idleCycles(3);
        checkSmall("gaps");

        $display("[TB] reset during partial frame");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sValid = 1'b1;
            sData  = DW'(i + 1);
        end
        @(negedge clk);
        sValid = 1'b1;
        sData  = DW'(6);
        sReset = 1'b1;
        @(negedge clk);
        sReset = 1'b0;
        sValid = 1'b0;
        checkOutput("prst_valid", sOutValid, 0);
        checkOutput("prst_data", sOutData, 0);
        checkOutput("prst_done", sDone, 0);
        idleCycles(2);
        checkOutput("prst_partial_outputs", sObsData.size(), 0);
        sObsData.delete(); sObsDone.delete(); sObsCyc.delete();
        for (int i = 0; i < 16; i++) p[i] = i + 21;
        applyStimulus(p, 0);
        idleCycles(3);
        checkSmall("after_rst");

        $display("[TB] back-to-back frames");
        for (int i = 0; i < 16; i++) p[i] = i + 1;
        applyStimulus(p, 0);
        for (int i = 0; i < 16; i++) p[i] = i + 101;
        applyStimulus(p, 0);
        idleCycles(3);
        doneCount = 0;
        foreach (sObsDone[i]) if (sObsDone[i] === 1'b1) doneCount++;
        checkOutput("b2b_done_pulses", doneCount, 2);
        checkSmall("b2b");
        checkOutput("small_stray_done", sStrayDone, 0);

        $display("[TB] random frames on %0dx%0d", BW, BH);
        for (int f = 0; f < BFRAMES; f++) begin
            for (int i = 0; i < BW*BH; i++) bPix[i] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < BW*BH; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) begin
                    bValid = 1'b0;
                    @(negedge clk);
                end
                bValid  = 1'b1;
                bData   = DW'(bPix[i]);
                bDrv[i] = cyc;
            end
            for (int r = 0; r < BH/2; r++) begin
                for (int c = 0; c < BW/2; c++) begin
                    bExpData.push_back(pool4(bPix[2*r*BW + 2*c], bPix[2*r*BW + 2*c + 1],
                                             bPix[(2*r+1)*BW + 2*c], bPix[(2*r+1)*BW + 2*c + 1]));
                    bExpDone.push_back((r == BH/2-1) && (c == BW/2-1));
                    bExpCyc.push_back(bDrv[(2*r+1)*BW + 2*c + 1] + 1);
                end
            end
        end
        idleCycles(3);
        checkOutput("big_count", bObsData.size(), BFRAMES * (BW/2) * (BH/2));
        doneCount = 0;
        foreach (bObsDone[i]) if (bObsDone[i] === 1'b1) doneCount++;
        checkOutput("big_done_pulses", doneCount, BFRAMES);
        for (int i = 0; i < bExpData.size() && i < bObsData.size(); i++) begin
            checkOutput($sformatf("big_data%0d", i), bObsData[i], bExpData[i]);
            checkOutput($sformatf("big_done%0d", i), bObsDone[i], bExpDone[i]);
            checkOutput($sformatf("big_cyc%0d", i), bObsCyc[i], bExpCyc[i]);
        end
        checkOutput("big_stray_done", bStrayDone, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
